fifo_uart_tx: RTL and testbench

- Downstream drain stage for the cyclic byte FIFO: pops bytes over the FIFO read interface (read request, read data, read-data-valid, empty flag) and serializes each byte onto a UART TX line, 8N1, LSB first.
- Sits between the FIFO read port and the chip pad.
- Never requests a read while the FIFO reports empty, so it cannot cause FIFO underflow.

---
 rtl/uart_tx_pkg.sv | 20 ++
 rtl/uart_baud_tick.sv | 31 +++
 rtl/fifo_uart_tx.sv | 150 +++++++++++++++
 tb/tb_fifo_uart_tx.sv | 375 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_pkg.sv
// Shared types and defaults for the UART transmit path.
package uart_tx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  localparam int DATA_W_DEF       = 8;
  localparam int CLKS_PER_BIT_DEF = 16;

  // Wide enough to index the data bits of a byte and the stop bits.
  localparam int BIT_CNT_W = 3;

endpackage

// File: rtl/uart_baud_tick.sv
// Free-running baud divider: a down-counter that emits a one-cycle tick
// every CLKS_PER_BIT cycles. A synchronous clear reloads it so that the
// first tick lands exactly CLKS_PER_BIT cycles after clear is released.
module uart_baud_tick #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt;

  // Count down and wrap back to the reload value at zero or on clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr || (cnt == '0)) begin
      cnt <= RELOAD;
    end else begin
      cnt <= cnt - 1'b1;
    end
  end

  assign tick = (cnt == '0) && !clr;

endmodule

// File: rtl/fifo_uart_tx.sv
// FIFO drain stage: pops bytes from the byte FIFO and sends them as UART
// frames (start bit, DATA_W data bits LSB first, STOP_BITS stop bits).
// Define UART_TX_PARITY_EN to insert an even-parity bit before the stop bits.
// frame_done is registered on the edge that ends the last stop bit, so it is
// high during the first cycle after the frame.
module fifo_uart_tx
  import uart_tx_pkg::*;
#(
  parameter int DATA_W       = DATA_W_DEF,
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter int STOP_BITS    = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              fifo_empty,
  output logic              read_req,
  input  logic [DATA_W-1:0] read_data,
  input  logic              read_data_valid,
  output logic              tx,
  output logic              busy,
  output logic              frame_done
);

  localparam logic [BIT_CNT_W-1:0] LAST_DATA = BIT_CNT_W'(DATA_W - 1);
  localparam logic [BIT_CNT_W-1:0] LAST_STOP = BIT_CNT_W'(STOP_BITS - 1);

  state_t               state;
  logic [DATA_W-1:0]    shift;
  logic [BIT_CNT_W-1:0] bit_cnt;
  logic                 baud_clr;
  logic                 baud_tick;
  logic                 pop_ok;
`ifdef UART_TX_PARITY_EN
  logic                 parity;
`endif

  assign pop_ok = enable && !fifo_empty;

  // Hold the divider in reload until the byte arrives so the start bit is
  // a full bit period long regardless of FIFO read latency.
  assign baud_clr = (state == IDLE) || (state == REQ) || (state == WAIT);

  uart_baud_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk  (clk),
    .rst  (rst),
    .clr  (baud_clr),
    .tick (baud_tick)
  );

  // Frame sequencer with registered tx, read_req, busy and frame_done.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      tx         <= 1'b1;
      read_req   <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      shift      <= '0;
      bit_cnt    <= '0;
`ifdef UART_TX_PARITY_EN
      parity     <= 1'b0;
`endif
    end else begin
      read_req   <= 1'b0;
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          tx <= 1'b1;
          if (pop_ok) begin
            state    <= REQ;
            read_req <= 1'b1;
            busy     <= 1'b1;
          end
        end
        REQ: begin
          state <= WAIT;
        end
        WAIT: begin
          if (read_data_valid) begin
            shift  <= read_data;
`ifdef UART_TX_PARITY_EN
            parity <= ^read_data;
`endif
            state  <= START;
            tx     <= 1'b0;
          end
        end
        START: begin
          if (baud_tick) begin
            state   <= DATA;
            bit_cnt <= '0;
            tx      <= shift[0];
          end
        end
        DATA: begin
          if (baud_tick) begin
            if (bit_cnt == LAST_DATA) begin
              bit_cnt <= '0;
`ifdef UART_TX_PARITY_EN
              state   <= PARITY;
              tx      <= parity;
`else
              state   <= STOP;
              tx      <= 1'b1;
`endif
            end else begin
              shift   <= shift >> 1;
              bit_cnt <= bit_cnt + 1'b1;
              tx      <= shift[1];
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (baud_tick) begin
            state <= STOP;
            tx    <= 1'b1;
          end
        end
`endif
        STOP: begin
          if (baud_tick) begin
            if (bit_cnt == LAST_STOP) begin
              frame_done <= 1'b1;
              bit_cnt    <= '0;
              if (pop_ok) begin
                state    <= REQ;
                read_req <= 1'b1;
                busy     <= 1'b1;
              end else begin
                state <= IDLE;
                busy  <= 1'b0;
              end
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end
        default: begin
          state <= IDLE;
          tx    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: FIFO model with configurable read latency, a
// line monitor that captures whole frames, and per-scenario checks against
// frames built from the byte values.
`timescale 1ns/1ps
module tb_fifo_uart_tx;

  localparam int DATA_W    = 8;
  localparam int CLKS      = 4;
  localparam int STOP_BITS = 1;
`ifdef UART_TX_PARITY_EN
  localparam int PAR_BITS  = 1;
`else
  localparam int PAR_BITS  = 0;
`endif
  localparam int NB        = 1 + DATA_W + PAR_BITS + STOP_BITS;
  localparam int FRAME_CYC = NB * CLKS;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              enable = 1'b0;
  logic              fifo_empty = 1'b1;
  logic              read_req;
  logic [DATA_W-1:0] read_data = '0;
  logic              read_data_valid = 1'b0;
  logic              tx;
  logic              busy;
  logic              frame_done;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  fifo_uart_tx #(
    .DATA_W(DATA_W),
    .CLKS_PER_BIT(CLKS),
    .STOP_BITS(STOP_BITS)
  ) dut (
    .clk(clk),
    .rst(rst),
    .enable(enable),
    .fifo_empty(fifo_empty),
    .read_req(read_req),
    .read_data(read_data),
    .read_data_valid(read_data_valid),
    .tx(tx),
    .busy(busy),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
  end

  // FIFO model: pop on read_req, present the byte 'lat' cycles later.
  logic [7:0] fifo_q[$];
  int         lat = 1;
  int         pend_cnt = 0;
  logic [7:0] pend_data = '0;
  bit         spur_en = 1'b0;
  int         rr_count = 0;
  int         uf_count = 0;

  initial forever begin
    @(negedge clk);
    read_data_valid = 1'b0;
    read_data       = 8'($urandom);
    if (!rst) begin
      pend_cnt = 0;
    end else begin
      if (pend_cnt > 0) begin
        pend_cnt = pend_cnt - 1;
        if (pend_cnt == 0) begin
          read_data_valid = 1'b1;
          read_data       = pend_data;
        end
      end else if (spur_en && !read_req && ($urandom_range(0, 3) == 0)) begin
        read_data_valid = 1'b1;
      end
      if (read_req) begin
        rr_count = rr_count + 1;
        if (fifo_q.size() == 0) begin
          uf_count = uf_count + 1;
        end else begin
          pend_data = fifo_q.pop_front();
          pend_cnt  = lat;
        end
      end
    end
    fifo_empty = (fifo_q.size() == 0);
  end

  // Line monitor: capture NB bit periods starting at each start-bit edge.
  logic [NB-1:0] mon_bits = '0;
  int            mon_idx = 0;
  bit            mon_active = 1'b0;
  bit            mon_stable = 1'b1;
  int            mon_start = 0;
  logic [NB-1:0] frm_bits[$];
  bit            frm_stable[$];
  int            frm_start[$];
  bit            frm_busy[$];
  int            fd_cyc[$];
  int            tx_low_cnt = 0;
  int            busy_cnt = 0;

  initial forever begin
    @(negedge clk);
    if (frame_done) fd_cyc.push_back(cyc);
    if (!tx) tx_low_cnt = tx_low_cnt + 1;
    if (busy) busy_cnt = busy_cnt + 1;
    if (!rst) begin
      mon_active = 1'b0;
    end else begin
      if (!mon_active && !tx) begin
        mon_active = 1'b1;
        mon_idx    = 0;
        mon_bits   = '0;
        mon_stable = 1'b1;
        mon_start  = cyc;
        frm_busy.push_back(busy);
      end
      if (mon_active) begin
        if ((mon_idx % CLKS) == 0) mon_bits[mon_idx / CLKS] = tx;
        else if (tx !== mon_bits[mon_idx / CLKS]) mon_stable = 1'b0;
        mon_idx = mon_idx + 1;
        if (mon_idx == FRAME_CYC) begin
          frm_bits.push_back(mon_bits);
          frm_stable.push_back(mon_stable);
          frm_start.push_back(mon_start);
          mon_active = 1'b0;
        end
      end
    end
  end

  // Reference frame for a byte: start 0, data LSB first, even parity, stops 1.
  function automatic logic [NB-1:0] exp_frame(input logic [7:0] b);
    logic [NB-1:0] f;
    int ones;
    f    = '1;
    f[0] = 1'b0;
    ones = 0;
    for (int i = 0; i < DATA_W; i++) begin
      f[1 + i] = b[i];
      ones     = ones + int'(b[i]);
    end
`ifdef UART_TX_PARITY_EN
    f[1 + DATA_W] = ((ones % 2) == 1);
`endif
    return f;
  endfunction

  task automatic clear_obs();
    frm_bits.delete();
    frm_stable.delete();
    frm_start.delete();
    frm_busy.delete();
    fd_cyc.delete();
  endtask

  task automatic wait_frames(input int n, input int budget, output bit ok);
    int k;
    k = 0;
    while ((frm_bits.size() < n) && (k < budget)) begin
      @(negedge clk);
      k++;
    end
    repeat (3) @(negedge clk);
    ok = (frm_bits.size() >= n);
  endtask

  task automatic wait_tx_low(input int budget, output bit ok);
    int k;
    k = 0;
    while ((tx !== 1'b0) && (k < budget)) begin
      @(negedge clk);
      k++;
    end
    ok = (tx === 1'b0);
  endtask

  task automatic test_reset();
    int rr0;
    #1 rst = 1'b0;
    enable = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++; if (tx !== 1'b1) $display("FAIL reset_tx got %b want 1", tx); else n_pass++;
    n_checks++; if (read_req !== 1'b0) $display("FAIL reset_read_req got %b want 0", read_req); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else n_pass++;
    n_checks++; if (frame_done !== 1'b0) $display("FAIL reset_frame_done got %b want 0", frame_done); else n_pass++;
    rst = 1'b1;
    clear_obs();
    rr0 = rr_count;
    tx_low_cnt = 0;
    busy_cnt = 0;
    repeat (100) @(negedge clk);
    n_checks++; if (rr_count != rr0) $display("FAIL empty_no_pop got %0d pops want 0", rr_count - rr0); else n_pass++;
    n_checks++; if (tx_low_cnt != 0) $display("FAIL empty_tx_idle got %0d low cycles want 0", tx_low_cnt); else n_pass++;
    n_checks++; if (busy_cnt != 0) $display("FAIL empty_busy got %0d busy cycles want 0", busy_cnt); else n_pass++;
  endtask

  task automatic test_single();
    int rr0;
    bit ok;
    clear_obs();
    rr0 = rr_count;
    fifo_q.push_back(8'hA5);
    wait_frames(1, 200, ok);
    n_checks++; if (!ok) $display("FAIL single_timeout got %0d frames want 1", frm_bits.size()); else n_pass++;
    if (ok) begin
      n_checks++; if (frm_bits[0] !== exp_frame(8'hA5)) $display("FAIL single_bits got %h want %h", frm_bits[0], exp_frame(8'hA5)); else n_pass++;
      n_checks++; if (!frm_stable[0]) $display("FAIL single_bit_width got glitch want %0d-cycle bits", CLKS); else n_pass++;
      n_checks++; if (frm_busy[0] !== 1'b1) $display("FAIL single_busy_in_frame got %b want 1", frm_busy[0]); else n_pass++;
      n_checks++; if (fd_cyc.size() != 1) $display("FAIL single_fd_count got %0d want 1", fd_cyc.size()); else n_pass++;
      if (fd_cyc.size() == 1) begin
        n_checks++; if (fd_cyc[0] - frm_start[0] != FRAME_CYC) $display("FAIL single_fd_time got %0d want %0d", fd_cyc[0] - frm_start[0], FRAME_CYC); else n_pass++;
      end
    end
    n_checks++; if (rr_count - rr0 != 1) $display("FAIL single_pops got %0d want 1", rr_count - rr0); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL single_busy_after got %b want 0", busy); else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [7:0] b[3];
    int rr0;
    int uf0;
    bit ok;
    b[0] = 8'h3C; b[1] = 8'hFF; b[2] = 8'h00;
    clear_obs();
    rr0 = rr_count;
    uf0 = uf_count;
    for (int i = 0; i < 3; i++) fifo_q.push_back(b[i]);
    wait_frames(3, 3 * (FRAME_CYC + 20), ok);
    n_checks++; if (!ok) $display("FAIL b2b_timeout got %0d frames want 3", frm_bits.size()); else n_pass++;
    if (ok) begin
      for (int i = 0; i < 3; i++) begin
        n_checks++; if (frm_bits[i] !== exp_frame(b[i])) $display("FAIL b2b_bits[%0d] got %h want %h", i, frm_bits[i], exp_frame(b[i])); else n_pass++;
        n_checks++; if (!frm_stable[i]) $display("FAIL b2b_bit_width[%0d] got glitch want stable", i); else n_pass++;
      end
      for (int i = 1; i < 3; i++) begin
        n_checks++; if (frm_start[i] - frm_start[i-1] != FRAME_CYC + 2) $display("FAIL b2b_spacing[%0d] got %0d want %0d", i, frm_start[i] - frm_start[i-1], FRAME_CYC + 2); else n_pass++;
      end
      n_checks++; if (fd_cyc.size() != 3) $display("FAIL b2b_fd_count got %0d want 3", fd_cyc.size()); else n_pass++;
    end
    n_checks++; if (rr_count - rr0 != 3) $display("FAIL b2b_pops got %0d want 3", rr_count - rr0); else n_pass++;
    n_checks++; if (uf_count != uf0) $display("FAIL b2b_underflow got %0d want 0", uf_count - uf0); else n_pass++;
  endtask

  task automatic test_random();
    logic [7:0] b[6];
    int rr0;
    int uf0;
    bit ok;
    clear_obs();
    rr0 = rr_count;
    uf0 = uf_count;
    lat = $urandom_range(1, 4);
    spur_en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      b[i] = 8'($urandom);
      fifo_q.push_back(b[i]);
    end
    wait_frames(6, 6 * (FRAME_CYC + 20), ok);
    n_checks++; if (!ok) $display("FAIL rand_timeout got %0d frames want 6", frm_bits.size()); else n_pass++;
    if (ok) begin
      for (int i = 0; i < 6; i++) begin
        n_checks++; if (frm_bits[i] !== exp_frame(b[i])) $display("FAIL rand_bits[%0d] lat %0d got %h want %h", i, lat, frm_bits[i], exp_frame(b[i])); else n_pass++;
        n_checks++; if (!frm_stable[i]) $display("FAIL rand_bit_width[%0d] got glitch want stable", i); else n_pass++;
      end
      n_checks++; if (fd_cyc.size() != 6) $display("FAIL rand_fd_count got %0d want 6", fd_cyc.size()); else n_pass++;
      if (fd_cyc.size() == 6) begin
        for (int i = 0; i < 6; i++) begin
          n_checks++; if (fd_cyc[i] - frm_start[i] != FRAME_CYC) $display("FAIL rand_fd_time[%0d] got %0d want %0d", i, fd_cyc[i] - frm_start[i], FRAME_CYC); else n_pass++;
        end
      end
    end
    n_checks++; if (rr_count - rr0 != 6) $display("FAIL rand_pops got %0d want 6", rr_count - rr0); else n_pass++;
    n_checks++; if (uf_count != uf0) $display("FAIL rand_underflow got %0d want 0", uf_count - uf0); else n_pass++;
    lat = 1;
    spur_en = 1'b0;
  endtask

  task automatic test_enable_drop();
    logic [7:0] b0;
    logic [7:0] b1;
    int rr0;
    bit ok;
    b0 = 8'($urandom);
    b1 = 8'($urandom);
    clear_obs();
    rr0 = rr_count;
    fifo_q.push_back(b0);
    fifo_q.push_back(b1);
    wait_tx_low(50, ok);
    n_checks++; if (!ok) $display("FAIL en_start_timeout got tx %b want 0", tx); else n_pass++;
    repeat (15) @(negedge clk);
    enable = 1'b0;
    wait_frames(1, 2 * FRAME_CYC, ok);
    repeat (60) @(negedge clk);
    n_checks++; if (frm_bits.size() != 1) $display("FAIL en_frames_while_off got %0d want 1", frm_bits.size()); else n_pass++;
    if (ok) begin
      n_checks++; if (frm_bits[0] !== exp_frame(b0)) $display("FAIL en_frame1_bits got %h want %h", frm_bits[0], exp_frame(b0)); else n_pass++;
    end
    n_checks++; if (rr_count - rr0 != 1) $display("FAIL en_pops_while_off got %0d want 1", rr_count - rr0); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL en_busy_while_off got %b want 0", busy); else n_pass++;
    enable = 1'b1;
    wait_frames(2, 2 * FRAME_CYC, ok);
    n_checks++; if (!ok) $display("FAIL en_resume_timeout got %0d frames want 2", frm_bits.size()); else n_pass++;
    if (ok) begin
      n_checks++; if (frm_bits[1] !== exp_frame(b1)) $display("FAIL en_frame2_bits got %h want %h", frm_bits[1], exp_frame(b1)); else n_pass++;
    end
    n_checks++; if (rr_count - rr0 != 2) $display("FAIL en_pops_resume got %0d want 2", rr_count - rr0); else n_pass++;
  endtask

  task automatic test_reset_mid();
    bit ok;
    clear_obs();
    fifo_q.push_back(8'($urandom));
    wait_tx_low(50, ok);
    n_checks++; if (!ok) $display("FAIL rmid_start_timeout got tx %b want 0", tx); else n_pass++;
    // Start bit plus three data bits, then halfway into data bit 3.
    repeat (4 * CLKS + CLKS / 2) @(negedge clk);
    rst = 1'b0;
    #1;
    n_checks++; if (tx !== 1'b1) $display("FAIL rmid_tx got %b want 1", tx); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL rmid_busy got %b want 0", busy); else n_pass++;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    clear_obs();
    fifo_q.push_back(8'h5A);
    wait_frames(1, 2 * FRAME_CYC, ok);
    n_checks++; if (!ok) $display("FAIL rmid_next_timeout got %0d frames want 1", frm_bits.size()); else n_pass++;
    if (ok) begin
      n_checks++; if (frm_bits[0] !== exp_frame(8'h5A)) $display("FAIL rmid_next_bits got %h want %h", frm_bits[0], exp_frame(8'h5A)); else n_pass++;
      n_checks++; if (!frm_stable[0]) $display("FAIL rmid_next_width got glitch want stable"); else n_pass++;
    end
  endtask

`ifdef UART_TX_PARITY_EN
  task automatic test_parity();
    bit ok;
    clear_obs();
    fifo_q.push_back(8'h07);
    fifo_q.push_back(8'h03);
    wait_frames(2, 3 * FRAME_CYC, ok);
    n_checks++; if (!ok) $display("FAIL par_timeout got %0d frames want 2", frm_bits.size()); else n_pass++;
    if (ok) begin
      n_checks++; if (frm_bits[0][9] !== 1'b1) $display("FAIL par_07 got %b want 1", frm_bits[0][9]); else n_pass++;
      n_checks++; if (frm_bits[1][9] !== 1'b0) $display("FAIL par_03 got %b want 0", frm_bits[1][9]); else n_pass++;
      n_checks++; if (fd_cyc.size() < 1) $display("FAIL par_fd_count got %0d want 2", fd_cyc.size()); else n_pass++;
      if (fd_cyc.size() >= 1) begin
        n_checks++; if (fd_cyc[0] - frm_start[0] != 44) $display("FAIL par_frame_len got %0d want 44", fd_cyc[0] - frm_start[0]); else n_pass++;
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_random();
    test_enable_drop();
    test_reset_mid();
`ifdef UART_TX_PARITY_EN
    test_parity();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
